// File: rtl/host_cmd_decoder.sv
// Host byte-stream command decoder: drains the host FIFO into
// video-memory writes and control-register writes.
module host_cmd_decoder #(
  parameter int ADDR_W   = 16,
  parameter int NUM_REGS = 16
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              fifo_not_empty,
  output logic              fifo_rd,
  input  logic [7:0]        fifo_data,
  output logic              mem_wr_valid,
  input  logic              mem_wr_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_data,
  output logic              reg_wr,
  output logic [7:0]        reg_idx,
  output logic [7:0]        reg_data,
  output logic              busy,
  output logic              err
);

  typedef enum logic [2:0] {
    S_CMD,
    S_ALO,
    S_AHI,
    S_CNT,
    S_DATA,
    S_RIDX,
    S_RVAL
  } state_t;

  state_t      state, state_nx;
  logic        take, take_nx;
  logic [7:0]  lo_q;
  logic [7:0]  idx_q;
  logic [8:0]  remaining;
  logic        pop;
  logic        mem_acc;

  assign pop     = !take && fifo_not_empty && !mem_wr_valid;
  assign fifo_rd = !(nrst && pop);
  assign mem_acc = mem_wr_valid && mem_wr_ready;
  assign busy    = !(state == S_CMD && !take);

  always_comb begin
    state_nx = state;
    take_nx  = take;
    if (take) begin
      take_nx = 1'b0;
      unique case (state)
        S_CMD: begin
          unique case (1'b1)
            fifo_data == 8'h01: state_nx = S_ALO;
            fifo_data == 8'h02: state_nx = S_CNT;
            fifo_data == 8'h03: state_nx = S_RIDX;
            default:            state_nx = S_CMD;
          endcase
        end
        S_ALO:   state_nx = S_AHI;
        S_AHI:   state_nx = S_CMD;
        S_CNT:   state_nx = S_DATA;
        S_DATA:  state_nx = S_DATA;
        S_RIDX:  state_nx = S_RVAL;
        S_RVAL:  state_nx = S_CMD;
        default: state_nx = S_CMD;
      endcase
    end else if (pop) begin
      take_nx = 1'b1;
    end else if (mem_acc && remaining == 9'd1) begin
      state_nx = S_CMD;
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state        <= S_CMD;
      take         <= 1'b0;
      lo_q         <= '0;
      idx_q        <= '0;
      remaining    <= '0;
      mem_wr_valid <= 1'b0;
      mem_addr     <= '0;
      mem_data     <= '0;
      reg_wr       <= 1'b0;
      reg_idx      <= '0;
      reg_data     <= '0;
      err          <= 1'b0;
    end else begin
      state  <= state_nx;
      take   <= take_nx;
      reg_wr <= 1'b0;
      if (take) begin
        unique case (state)
          S_CMD:  if (fifo_data > 8'h03) err <= 1'b1;
          S_ALO:  lo_q <= fifo_data;
          S_AHI:  mem_addr <= ADDR_W'({fifo_data, lo_q});
          S_CNT:  remaining <= (fifo_data == 8'h00) ? 9'd256
                               : {1'b0, fifo_data};
          S_DATA: begin
            mem_data     <= fifo_data;
            mem_wr_valid <= 1'b1;
          end
          S_RIDX: idx_q <= fifo_data;
          S_RVAL: begin
            if (32'(idx_q) < NUM_REGS) begin
              reg_wr   <= 1'b1;
              reg_idx  <= idx_q;
              reg_data <= fifo_data;
            end else begin
              err <= 1'b1;
            end
          end
          default: ;
        endcase
      end
      // write retires: advance address, count down payload
      if (mem_acc) begin
        mem_wr_valid <= 1'b0;
        mem_addr     <= mem_addr + ADDR_W'(1);
        remaining    <= remaining - 9'd1;
      end
    end
  end

endmodule

// File: doc/host_cmd_decoder.md
Name: host_cmd_decoder

Overview:
Drains the 512x8 host byte FIFO and turns its byte stream into video-memory writes and control-register writes. It sits directly downstream of the FIFO: it drives the FIFO's active-low read strobe and consumes its registered read data. The memory write port uses a valid/ready handshake; the register write port is a single-cycle strobe.

Parameters:
ADDR_W, 16, memory address width; the address counter wraps modulo 2^ADDR_W
NUM_REGS, 16, number of control registers; indices >= NUM_REGS are rejected

Ports:
clk  input  1  system clock
nrst  input  1  synchronous active-low reset
fifo_not_empty  input  1  FIFO holds at least one byte
fifo_rd  output  1  active-low pop request to FIFO
fifo_data  input  8  FIFO read data, valid the cycle after a pop
mem_wr_valid  output  1  memory write request pending
mem_wr_ready  input  1  memory side accepts the write this cycle
mem_addr  output  ADDR_W  memory write address
mem_data  output  8  memory write data
reg_wr  output  1  one-cycle register write strobe
reg_idx  output  8  register index
reg_data  output  8  register value
busy  output  1  high while a command is partially received
err  output  1  sticky protocol-error flag

Behaviour:
- Reset: nrst sampled low at a clk edge does the following:
  - state <= CMD; fifo_rd=1; mem_wr_valid=0; mem_addr=0; mem_data=0.
  - reg_wr=0; reg_idx=0; reg_data=0; busy=0; err=0.
  - A pending memory write is dropped. Bytes already popped are lost.
- Byte fetch: every byte-consuming state has two phases, FETCH and TAKE.
  - FETCH: fifo_rd = 0 combinationally iff fifo_not_empty=1 and mem_wr_valid=0; otherwise fifo_rd = 1. If fifo_rd=0, go to TAKE at the next edge.
  - TAKE: sample fifo_data; fifo_rd=1.
  - Peak rate is 1 byte per 2 cycles. An empty FIFO stalls in FETCH indefinitely.
- Command stream: first byte in CMD selects the command.
  - 0x00 NOP: no payload; stay in CMD.
  - 0x01 SET_ADDR: two payload bytes, lo then hi, via ADDR_LO then ADDR_HI.
    - mem_addr updates only after hi is taken: {hi, lo}, truncated to ADDR_W.
  - 0x02 WRITE_N: count byte (COUNT), then N data bytes (DATA). Count 0x00 means 256 bytes.
  - 0x03 REG_WRITE: idx byte, then val byte, via REG_IDX then REG_VAL.
  - Any other byte: set err=1; stay in CMD; no payload is consumed.
- WRITE_N data flow:
  - On DATA/TAKE edge: mem_data <= fifo_data; mem_wr_valid <= 1, so it is asserted the next cycle.
  - mem_addr and mem_data are held stable while mem_wr_valid=1.
  - On an edge with mem_wr_valid & mem_wr_ready:
    - mem_wr_valid <= 0; mem_addr <= mem_addr+1, wrapping all-ones to 0; remaining <= remaining-1.
    - Next state is DATA/FETCH if remaining != 0, else CMD.
  - No pop occurs while mem_wr_valid=1.
  - mem_addr persists across commands, so consecutive WRITE_N commands continue sequentially.
- REG_WRITE:
  - On REG_VAL/TAKE edge: reg_wr <= 1 for exactly one cycle, with reg_idx and reg_data valid in that cycle.
  - If idx >= NUM_REGS: no strobe, and set err=1.
  - reg_idx and reg_data hold their last values after the strobe.
- busy = 1 in any state other than CMD/FETCH, including during a pending memory write.
- err clears only on reset.

Test Plan:
- Reset, then FIFO holds {01,34,12,02,03,AA,BB,CC}; mem_wr_ready=1. Expect writes (0x1234,AA), (0x1235,BB), (0x1236,CC); mem_addr=0x1237 after; busy=0; err=0.
- Same stream with mem_wr_ready low for 5 cycles per write. Expect mem_wr_valid/addr/data stable throughout; fifo_rd stays 1 while valid; no bytes lost.
- Stream {01,FF,FF,02,02,11,22}. Expect writes (0xFFFF,11) then (0x0000,22).
- Stream {02,00} followed by 256 bytes of 0..255 from addr 0. Expect exactly 256 writes at addr 0..255, then return to CMD.
- Stream {03,05,7E,03,20,01,5A}. Expect:
  - One reg_wr pulse with idx=5, data=7E.
  - No strobe for idx 0x20; err=1.
  - Byte 5A is rejected as an unknown command; err stays 1.
- Pull nrst low during a WRITE_N with mem_wr_valid=1. Expect all outputs at reset values the next cycle; a subsequent {00} is decoded as NOP.
